// File: rtl/bulbul_pkg.sv
// ============================================================================
// Module      : bulbul_pkg
// Description : Shared types for the operand-A stage: select codes, beat
//               payload, occupancy FSM states and the operand-A resolver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bulbul_pkg;

  localparam int unsigned OPA_XLEN = 32;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_RSVD = 2'b01,
    OPA_PC   = 2'b10,
    OPA_ZERO = 2'b11
  } opa_sel_e;

  typedef struct packed {
    logic [OPA_XLEN-1:0] opa;
    logic [OPA_XLEN-1:0] pc;
    logic                illegal;
  } opa_beat_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_HALF  = 2'd1,
    OCC_FULL  = 2'd2
  } opa_occ_e;

  // Reserved code resolves to zero so the ALU never sees an undefined operand.
  function automatic opa_beat_t opa_resolve(input logic [1:0]          sel,
                                            input logic [OPA_XLEN-1:0] rs1,
                                            input logic [OPA_XLEN-1:0] pc);
    opa_beat_t b;
    b.pc      = pc;
    b.opa     = '0;
    b.illegal = 1'b0;
    case (opa_sel_e'(sel))
      OPA_RS1:  b.opa = rs1;
      OPA_PC:   b.opa = pc;
      OPA_ZERO: b.opa = '0;
      default:  b.illegal = 1'b1;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opa_skid_buf.sv
// ============================================================================
// Module      : opa_skid_buf
// Description : Occupancy FSM with output register and, when EX_OPA_SKID_EN
//               is defined, a skid register giving a flop-only ready_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opa_skid_buf
  import bulbul_pkg::*;
#(
  parameter type T = opa_beat_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  input  logic flush_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  opa_occ_e r_state;
  logic     r_valid;
  T         r_out;
`ifdef EX_OPA_SKID_EN
  logic     r_ready;
  T         r_skid;
`endif

  logic w_enq;
  logic w_deq;

`ifdef EX_OPA_SKID_EN
  assign ready_o = r_ready;
`else
  assign ready_o = !r_valid || ready_i;
`endif
  assign valid_o = r_valid;
  assign data_o  = r_out;
  assign w_enq   = valid_i && ready_o;
  assign w_deq   = r_valid && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= OCC_EMPTY;
      r_valid <= 1'b0;
      r_out   <= '0;
`ifdef EX_OPA_SKID_EN
      r_ready <= 1'b1;
      r_skid  <= '0;
`endif
    end else if (flush_i) begin
      // Payload registers keep their value; only occupancy is cleared.
      r_state <= OCC_EMPTY;
      r_valid <= 1'b0;
`ifdef EX_OPA_SKID_EN
      r_ready <= 1'b1;
`endif
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_enq) begin
            r_out   <= data_i;
            r_valid <= 1'b1;
            r_state <= OCC_HALF;
          end
        end
        OCC_HALF: begin
`ifdef EX_OPA_SKID_EN
          if (w_enq && w_deq) begin
            r_out <= data_i;
          end else if (w_enq) begin
            r_skid  <= data_i;
            r_ready <= 1'b0;
            r_state <= OCC_FULL;
          end else if (w_deq) begin
            r_valid <= 1'b0;
            r_state <= OCC_EMPTY;
          end
`else
          // Without the skid entry an enqueue here always pairs with a dequeue.
          if (w_enq) begin
            r_out <= data_i;
          end else if (w_deq) begin
            r_valid <= 1'b0;
            r_state <= OCC_EMPTY;
          end
`endif
        end
`ifdef EX_OPA_SKID_EN
        OCC_FULL: begin
          if (w_deq) begin
            r_out   <= r_skid;
            r_ready <= 1'b1;
            r_state <= OCC_HALF;
          end
        end
`endif
        default: begin
          r_state <= OCC_EMPTY;
          r_valid <= 1'b0;
`ifdef EX_OPA_SKID_EN
          r_ready <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_operand_a_stage.sv
// ============================================================================
// Module      : ex_operand_a_stage
// Description : Registered operand-A stage: resolves rs1/PC/zero at capture
//               and hands the beat to execute. Option: EX_OPA_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_a_stage
  import bulbul_pkg::*;
#(
  parameter int unsigned XLEN = OPA_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      opasel_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] opa_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_sel_o
);

  opa_beat_t w_beat_in;
  opa_beat_t w_beat_out;

  assign w_beat_in = opa_resolve(opasel_i, rs1_data_i, pc_i);

  opa_skid_buf #(
    .T (opa_beat_t)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (w_beat_in),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (w_beat_out)
  );

  assign opa_o         = w_beat_out.opa;
  assign pc_o          = w_beat_out.pc;
  assign illegal_sel_o = w_beat_out.illegal;

endmodule

`default_nettype wire
